styler_row_serializer: RTL and testbench

//  Downstream of the character styler: takes one styled 16-pixel glyph row (bitmapOut) plus its

---
 rtl/styler_pkg.sv | 17 +
 rtl/styler_pix_shifter.sv | 73 +++++++
 rtl/styler_row_serializer.sv | 150 +++++++++++++++
 tb/tb_styler_row_serializer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/styler_pkg.sv
// Shared constants and types for the character styler pipeline.
package styler_pkg;

  localparam int STYLER_ROW_W   = 16;
  localparam int STYLER_COLOR_W = 4;

  typedef logic [STYLER_COLOR_W-1:0] color_idx_t;

  // Where the pixel for the current cycle comes from.
  typedef enum logic [1:0] {
    SRC_IDLE   = 2'd0,  // no strobe this cycle, outputs hold
    SRC_SHIFT  = 2'd1,  // next bit of the row already in the shifter
    SRC_LOAD   = 2'd2,  // first bit of the held row, rest moves into the shifter
    SRC_STARVE = 2'd3   // strobe with nothing to emit
  } pix_src_e;

endpackage

// File: rtl/styler_pix_shifter.sv
// Shift register for one styled row: data bits, remaining-pixel down-counter
// and the row's fg/bg indices. The first bit of a row is emitted by the parent
// straight from the holding register, so a load stores only the other bits.
module styler_pix_shifter
  import styler_pkg::*;
#(
  parameter int WIDTH     = STYLER_ROW_W,
  parameter int COLOR_W   = STYLER_COLOR_W,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               shift,
  input  logic [WIDTH-1:0]   load_bits,
  input  logic [COLOR_W-1:0] load_fg,
  input  logic [COLOR_W-1:0] load_bg,
  output logic               busy,
  output logic               cur_bit,
  output logic               last,
  output logic [COLOR_W-1:0] fg,
  output logic [COLOR_W-1:0] bg
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0]   data_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [COLOR_W-1:0] fg_q;
  logic [COLOR_W-1:0] bg_q;
  logic [WIDTH-1:0]   load_next;
  logic [WIDTH-1:0]   shift_next;

  // Bit-order mirroring only affects which end the data walks out of.
  always_comb begin
    load_next  = '0;
    shift_next = '0;
    if (MSB_FIRST != 0) begin
      load_next  = load_bits << 1;
      shift_next = data_q << 1;
    end else begin
      load_next  = load_bits >> 1;
      shift_next = data_q >> 1;
    end
  end

  // Row state: load replaces everything, shift consumes one bit while cnt>0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
      fg_q   <= '0;
      bg_q   <= '0;
    end else if (load) begin
      data_q <= load_next;
      cnt_q  <= CNT_LOAD;
      fg_q   <= load_fg;
      bg_q   <= load_bg;
    end else if (shift && (cnt_q != '0)) begin
      data_q <= shift_next;
      cnt_q  <= cnt_q - CNT_ONE;
    end
  end

  assign busy    = (cnt_q != '0);
  assign last    = (cnt_q == CNT_ONE);
  assign cur_bit = (MSB_FIRST != 0) ? data_q[WIDTH-1] : data_q[0];
  assign fg      = fg_q;
  assign bg      = bg_q;

endmodule

// File: rtl/styler_row_serializer.sv
// Row serializer: one-row holding register in front of a pixel shifter,
// emitting one colour index per pix_en strobe. The holding register lets the
// styler present the next row while the current one is still shifting out,
// so consecutive rows leave no bubble between them.
module styler_row_serializer
  import styler_pkg::*;
#(
  parameter int WIDTH     = STYLER_ROW_W,
  parameter int COLOR_W   = STYLER_COLOR_W,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_bitmap,
  input  logic [COLOR_W-1:0] in_fg,
  input  logic [COLOR_W-1:0] in_bg,
  input  logic               pix_en,
  input  logic               line_active,
  output logic [COLOR_W-1:0] pix_out,
  output logic               pix_valid,
  output logic               pix_last,
  output logic               underrun
);

  logic               hold_full;
  logic [WIDTH-1:0]   hold_bits;
  logic [COLOR_W-1:0] hold_fg;
  logic [COLOR_W-1:0] hold_bg;
  logic               hold_first;
  logic               accept;

  logic               sh_busy;
  logic               sh_bit;
  logic               sh_last;
  logic [COLOR_W-1:0] sh_fg;
  logic [COLOR_W-1:0] sh_bg;
  logic               sh_load;
  logic               sh_shift;

  pix_src_e           src;

  logic [COLOR_W-1:0] nxt_out;
  logic               nxt_valid;
  logic               nxt_last;
  logic               nxt_under;

  // Ready depends only on the holding register; a transfer into the shifter
  // can therefore never coincide with an accept.
  assign in_ready   = ~hold_full;
  assign accept     = in_valid & ~hold_full;
  assign hold_first = (MSB_FIRST != 0) ? hold_bits[WIDTH-1] : hold_bits[0];

  // Pick the pixel source: shifter first, then the held row, else starve.
  always_comb begin
    src = SRC_IDLE;
    if (pix_en) begin
      if (sh_busy) begin
        src = SRC_SHIFT;
      end else if (hold_full) begin
        src = SRC_LOAD;
      end else begin
        src = SRC_STARVE;
      end
    end
  end

  assign sh_load  = (src == SRC_LOAD);
  assign sh_shift = (src == SRC_SHIFT);

  // Next output values; without a strobe the pixel outputs simply hold.
  always_comb begin
    nxt_out   = pix_out;
    nxt_valid = pix_valid;
    nxt_last  = pix_last;
    nxt_under = 1'b0;
    unique case (src)
      SRC_SHIFT: begin
        nxt_out   = sh_bit ? sh_fg : sh_bg;
        nxt_valid = 1'b1;
        nxt_last  = sh_last;
      end
      SRC_LOAD: begin
        nxt_out   = hold_first ? hold_fg : hold_bg;
        nxt_valid = 1'b1;
        nxt_last  = (WIDTH == 1);
      end
      SRC_STARVE: begin
        nxt_out   = '0;
        nxt_valid = 1'b0;
        nxt_last  = 1'b0;
        nxt_under = line_active;
      end
      default: ;
    endcase
  end

  // Holding register: filled on accept, emptied when it moves into the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_bits <= '0;
      hold_fg   <= '0;
      hold_bg   <= '0;
    end else if (accept) begin
      hold_full <= 1'b1;
      hold_bits <= in_bitmap;
      hold_fg   <= in_fg;
      hold_bg   <= in_bg;
    end else if (sh_load) begin
      hold_full <= 1'b0;
    end
  end

  // Registered pixel stream towards the video output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_out   <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      pix_out   <= nxt_out;
      pix_valid <= nxt_valid;
      pix_last  <= nxt_last;
      underrun  <= nxt_under;
    end
  end

  styler_pix_shifter #(
    .WIDTH     (WIDTH),
    .COLOR_W   (COLOR_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_bits (hold_bits),
    .load_fg   (hold_fg),
    .load_bg   (hold_bg),
    .busy      (sh_busy),
    .cur_bit   (sh_bit),
    .last      (sh_last),
    .fg        (sh_fg),
    .bg        (sh_bg)
  );

endmodule

// File: tb/tb_styler_row_serializer.sv
// Directed bench for styler_row_serializer with a row/pixel scoreboard.
module tb_styler_row_serializer;
  import styler_pkg::*;

  typedef struct {
    logic [15:0] bm;
    color_idx_t  fg;
    color_idx_t  bg;
  } row_t;

  typedef struct {
    color_idx_t col;
    logic       last;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_bitmap = '0;
  color_idx_t  in_fg = '0;
  color_idx_t  in_bg = '0;
  logic        pix_en = 1'b0;
  logic        line_active = 1'b0;
  color_idx_t  pix_out;
  logic        pix_valid;
  logic        pix_last;
  logic        underrun;

  logic        l_in_valid = 1'b0;
  logic        l_in_ready;
  logic [15:0] l_in_bitmap = '0;
  color_idx_t  l_in_fg = '0;
  color_idx_t  l_in_bg = '0;
  logic        l_pix_en = 1'b0;
  color_idx_t  l_pix_out;
  logic        l_pix_valid;
  logic        l_pix_last;
  logic        l_underrun;

  int n_vec = 0;
  int n_err = 0;

  pix_t exp_q[$];
  row_t rows_q[$];
  color_idx_t e_out = '0;
  logic e_valid = 1'b0;
  logic e_last = 1'b0;
  logic e_under = 1'b0;

  always #5 clk = ~clk;

  styler_row_serializer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_bitmap   (in_bitmap),
    .in_fg       (in_fg),
    .in_bg       (in_bg),
    .pix_en      (pix_en),
    .line_active (line_active),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .pix_last    (pix_last),
    .underrun    (underrun)
  );

  styler_row_serializer #(.MSB_FIRST(0)) dut_lsb (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (l_in_valid),
    .in_ready    (l_in_ready),
    .in_bitmap   (l_in_bitmap),
    .in_fg       (l_in_fg),
    .in_bg       (l_in_bg),
    .pix_en      (l_pix_en),
    .line_active (1'b0),
    .pix_out     (l_pix_out),
    .pix_valid   (l_pix_valid),
    .pix_last    (l_pix_last),
    .underrun    (l_underrun)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [15:0] bm, input color_idx_t fg, input color_idx_t bg);
    row_t r;
    r.bm = bm;
    r.fg = fg;
    r.bg = bg;
    rows_q.push_back(r);
  endtask

  // One clock: drive producer and strobe, predict, then check after the edge.
  // The scoreboard holds every pixel of accepted rows not yet emitted, so the
  // holding register is full exactly when 16 or more are pending.
  task automatic tick(input logic pe, input logic la);
    logic acc;
    logic rdy_exp;
    row_t r;
    pix_t p;
    if (rows_q.size() > 0) begin
      in_valid  = 1'b1;
      in_bitmap = rows_q[0].bm;
      in_fg     = rows_q[0].fg;
      in_bg     = rows_q[0].bg;
    end else begin
      in_valid = 1'b0;
    end
    pix_en      = pe;
    line_active = la;
    rdy_exp = (exp_q.size() < 16);
    chk("in_ready", {7'b0, in_ready}, {7'b0, rdy_exp});
    acc = in_valid && rdy_exp;
    if (pe) begin
      if (exp_q.size() > 0) begin
        p       = exp_q.pop_front();
        e_out   = p.col;
        e_valid = 1'b1;
        e_last  = p.last;
        e_under = 1'b0;
      end else begin
        e_out   = '0;
        e_valid = 1'b0;
        e_last  = 1'b0;
        e_under = la;
      end
    end else begin
      e_under = 1'b0;
    end
    if (acc) begin
      r = rows_q.pop_front();
      for (int i = 15; i >= 0; i--) begin
        p.col  = r.bm[i] ? r.fg : r.bg;
        p.last = (i == 0);
        exp_q.push_back(p);
      end
    end
    @(posedge clk);
    #1;
    chk("pix_out", {4'b0, pix_out}, {4'b0, e_out});
    chk("pix_valid", {7'b0, pix_valid}, {7'b0, e_valid});
    chk("pix_last", {7'b0, pix_last}, {7'b0, e_last});
    chk("underrun", {7'b0, underrun}, {7'b0, e_under});
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_ready"}, {7'b0, in_ready}, 8'h01);
    chk({tag, "_out"}, {4'b0, pix_out}, 8'h00);
    chk({tag, "_valid"}, {7'b0, pix_valid}, 8'h00);
    chk({tag, "_last"}, {7'b0, pix_last}, 8'h00);
    chk({tag, "_under"}, {7'b0, underrun}, 8'h00);
  endtask

  initial begin
    logic [15:0] lbm;

    // 1: reset state, strobes outside the visible region never underrun
    #2;
    chk_cleared("rst");
    #10 rst_n = 1'b1;
    chk_cleared("rel");
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);

    // 2: single row, edge pixels foreground
    offer(16'h8001, 4'hF, 4'h1);
    for (int i = 0; i < 19; i++) tick(1'b1, 1'b0);

    // 3: back-to-back rows, gapless
    offer(16'hFFFF, 4'hE, 4'h2);
    offer(16'h0000, 4'h3, 4'h4);
    for (int i = 0; i < 36; i++) tick(1'b1, 1'b0);

    // 4: strobe every third cycle
    offer(16'hA5C3, 4'h7, 4'h8);
    for (int i = 0; i < 54; i++) tick((i % 3) == 0, 1'b0);

    // 5: starvation inside and outside the visible region
    offer(16'h1234, 4'h9, 4'h6);
    for (int i = 0; i < 18; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) tick(i[0], 1'b1);
    for (int i = 0; i < 2; i++) tick(1'b1, 1'b0);

    // 6: async reset at pixel 7 with the next row held
    offer(16'h5A5A, 4'hC, 4'h0);
    offer(16'h0F0F, 4'hB, 4'hD);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    chk("pre_rst_ready", {7'b0, in_ready}, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk_cleared("mid");
    exp_q.delete();
    rows_q.delete();
    in_valid = 1'b0;
    e_out = '0;
    e_valid = 1'b0;
    e_last = 1'b0;
    e_under = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
    offer(16'h00FF, 4'h5, 4'hA);
    for (int i = 0; i < 18; i++) tick(1'b1, 1'b0);

    // 6b: LSB-first instance, bit 0 goes out first
    lbm = 16'h0001;
    chk("lsb_ready0", {7'b0, l_in_ready}, 8'h01);
    l_in_valid  = 1'b1;
    l_in_bitmap = lbm;
    l_in_fg     = 4'hA;
    l_in_bg     = 4'h5;
    @(posedge clk);
    #1;
    l_in_valid = 1'b0;
    chk("lsb_ready1", {7'b0, l_in_ready}, 8'h00);
    for (int i = 0; i < 16; i++) begin
      l_pix_en = 1'b1;
      @(posedge clk);
      #1;
      chk("lsb_out", {4'b0, l_pix_out}, {4'b0, (lbm[i] ? 4'hA : 4'h5)});
      chk("lsb_valid", {7'b0, l_pix_valid}, 8'h01);
      chk("lsb_last", {7'b0, l_pix_last}, {7'b0, (i == 15)});
    end
    l_pix_en = 1'b0;
    chk("lsb_under", {7'b0, l_underrun}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
